// File: rtl/mygo_word_to_byte_stage.sv
// mygo_word_to_byte_stage
//
// Takes 32-bit words from the upstream word channel and emits each one as
// BYTES_PER_WORD bytes on the downstream byte channel. After NUM_WORDS words
// have been emitted completely, it posts one completion token on the done
// channel. Once that token is taken, the stage halts until reset.
//
// Handshake (all three channels): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer keeps valid and data stable
// until that transfer completes. in_ready, out_valid and done_valid are
// decoded from the registered state only. No input reaches them
// combinationally.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous reset, active low (0 = reset)
//   in_data     upstream word
//   in_valid    upstream word valid
//   in_ready    stage accepts a word (IDLE only)
//   out_data    current byte (0 when no byte is offered)
//   out_valid   byte valid (SHIFT only)
//   out_ready   downstream accepts the byte
//   done_data   completion token value, 1 whenever done_valid is high
//   done_valid  completion token valid (DONE only)
//   done_ready  completion token accepted
//   busy        high in SHIFT or DONE
//   word_count  number of words fully emitted since reset
//   state_dbg   raw FSM state: 0 IDLE, 1 SHIFT, 2 DONE, 3 HALT
//
// WORD_W must equal BYTE_W * BYTES_PER_WORD. NUM_WORDS ranges from 0 to 65535.
module mygo_word_to_byte_stage #(
  parameter int WORD_W         = 32,
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int NUM_WORDS      = 4,
  parameter int MSB_FIRST      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done_data,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              busy,
  output logic [15:0]       word_count,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [15:0]      WORDS_GOAL = 16'(NUM_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // With a zero-word job there is nothing to serialise. Reset goes straight
  // to DONE and the token is offered in the first cycle after reset release.
  localparam logic [1:0] S_RESET = (NUM_WORDS == 0) ? S_DONE : S_IDLE;

  logic [1:0]        state;
  logic [WORD_W-1:0] shift_reg;
  logic [IDX_W-1:0]  byte_idx;
  logic [15:0]       word_count_next;

  assign word_count_next = word_count + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // A partially emitted word is dropped here. No further bytes of it
      // are offered.
      state      <= S_RESET;
      shift_reg  <= '0;
      byte_idx   <= '0;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shift_reg <= in_data;
            byte_idx  <= '0;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (out_ready) begin
            // The emit end is always the byte presented on out_data. Shift
            // the next byte toward it and zero-fill the far end.
            if (MSB_FIRST != 0) begin
              shift_reg <= shift_reg << BYTE_W;
            end else begin
              shift_reg <= shift_reg >> BYTE_W;
            end
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == LAST_IDX) begin
              byte_idx   <= '0;
              word_count <= word_count_next;
              // Leaving for DONE exactly at the goal keeps word_count from
              // wrapping. Returning to IDLE otherwise gives the mandatory
              // one-cycle bubble between words.
              state      <= (word_count_next == WORDS_GOAL) ? S_DONE : S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (done_ready) begin
            state <= S_HALT;
          end
        end
        default: begin
          // HALT: no exit except reset, and word_count stays frozen.
          state <= S_HALT;
        end
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    if (state == S_SHIFT) begin
      if (MSB_FIRST != 0) begin
        out_data = shift_reg[WORD_W-1 -: BYTE_W];
      end else begin
        out_data = shift_reg[BYTE_W-1:0];
      end
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_SHIFT);
  assign done_valid = (state == S_DONE);
  assign done_data  = (state == S_DONE);
  assign busy       = (state == S_SHIFT) || (state == S_DONE);
  assign state_dbg  = state;

endmodule
